conv1d_pe: RTL and testbench
============================

CONV1D_PE -- requirements
Module: conv1d_pe

Interface
REQ-001 Parameter DW, default 2: width of each input sample and each filter tap (unsigned).
REQ-002 Parameter TAPS, default 3: number of filter taps (TAPS >= 1).
REQ-003 Parameter NOUT, default 3: number of output lanes per window (NOUT >= 1).
REQ-004 Parameter OW, default 2: width of each output lane.
REQ-005 Parameter SAT, default 0: 0 keeps the low OW bits of each sum; 1 clamps each sum to 2^OW-1.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 flt_load  in  1  load the filter register from flt_in this cycle.
REQ-009 flt_in  in  TAPS*DW  filter taps; tap t is bits [t*DW +: DW].
REQ-010 in_valid  in  1  in_data holds a valid window.
REQ-011 in_ready  out  1  block accepts a window this cycle.
REQ-012 in_data  in  (NOUT+TAPS-1)*DW  sample window; sample i is bits [i*DW +: DW].
REQ-013 out_valid  out  1  out_data/ovf hold a valid result.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_data  out  NOUT*OW  results; lane k is bits [k*OW +: OW].
REQ-016 ovf  out  NOUT  per-lane flag: the full-precision sum exceeds 2^OW-1.

Function
REQ-017 Lane k full-precision sum SHALL be S[k] = sum over t=0..TAPS-1 of x[k+t]*f[t], unsigned, carried in 2*DW+clog2(TAPS) bits with no intermediate truncation.
REQ-018 Lane output: SAT=0 gives S[k] mod 2^OW; SAT=1 gives min(S[k], 2^OW-1); ovf[k] = (S[k] > 2^OW-1) in both modes.
REQ-019 Two-state control: NOFLT (after reset, no filter loaded) and RUN; NOFLT->RUN on flt_load; RUN stays RUN; only rst returns to NOFLT.
REQ-020 in_ready SHALL be 0 in NOFLT and in any cycle with flt_load=1.
REQ-021 In RUN, in_ready = !flt_load && (!s1_valid || stage-1 advances this cycle).
REQ-022 A window SHALL be accepted when in_valid && in_ready; acceptance latches all TAPS*NOUT products, computed with the current filter register, into stage 1.
REQ-023 Stage 1 advances into stage 2 when !s2_valid || out_ready; stage 2 computes the sums and clip/truncate and drives out_data, ovf, out_valid = s2_valid.
REQ-024 Latency: result SHALL appear with out_valid=1 exactly 2 cycles after acceptance when unstalled; sustained throughput 1 window/cycle with out_ready held 1.
REQ-025 Stall: while out_valid && !out_ready, out_data and ovf SHALL hold stable and no accepted window is dropped or duplicated (max 2 in flight).
REQ-026 flt_load in RUN updates the filter on that edge; windows already in flight SHALL complete with the filter used at their acceptance.
REQ-027 Simultaneous flt_load and in_valid: the load takes effect and the window is not accepted (in_ready=0); the source retries.
REQ-028 Outputs SHALL be registered; no combinational path from in_data/flt_in to out_data.

Reset
REQ-029 rst=1 at an edge SHALL clear: filter register to 0, state to NOFLT, s1_valid/s2_valid to 0, out_valid 0, out_data 0, ovf 0, in_ready 0 the following cycle.
REQ-030 rst mid-operation SHALL discard all in-flight windows; no out_valid pulse for them after rst deasserts.
REQ-031 rst takes priority over flt_load, in_valid and out_ready in the same cycle.

Verification (defaults DW=2, TAPS=3, NOUT=3, OW=2)
REQ-032 Reset then in_valid=1, no flt_load for 10 cycles -> in_ready=0, out_valid=0, out_data=0 throughout.
REQ-033 flt_in=6'b00_00_01 loaded, in_data=10'h001 accepted at cycle N -> out_valid=1 at N+2, out_data=6'b00_00_01, ovf=3'b000.
REQ-034 flt_in=6'b01_01_01, in_data=10'h3FF: SAT=0 -> out_data=6'b01_01_01, ovf=3'b111; SAT=1 -> out_data=6'b11_11_11, ovf=3'b111.
REQ-035 Five back-to-back windows with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full, out_data is stable while stalled, all five results emerge in order, none lost or repeated.
REQ-036 flt_load asserted with in_valid in the same cycle while one window is in flight -> in_ready=0 that cycle; the in-flight result uses the old filter and the next accepted window uses the new filter.
REQ-037 rst pulsed one cycle with two windows in flight -> no out_valid afterwards, state NOFLT, and a reload is required before the next acceptance.

Source files
------------

// File: rtl/conv1d_pe_if.sv
// conv1d_pe_if: bundles the filter-load, input-window and result handshake
// signals of conv1d_pe.
//   master : side that drives filters/windows and consumes results
//   slave  : the processing element itself
interface conv1d_pe_if #(
  parameter int DW   = 2,
  parameter int TAPS = 3,
  parameter int NOUT = 3,
  parameter int OW   = 2
) ();
  logic                       flt_load;
  logic [TAPS*DW-1:0]         flt_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [(NOUT+TAPS-1)*DW-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [NOUT*OW-1:0]         out_data;
  logic [NOUT-1:0]            ovf;

  modport master (
    output flt_load, flt_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  flt_load, flt_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/conv1d_pe.sv
// conv1d_pe: 1-D convolution processing element. Each accepted window of
// NOUT+TAPS-1 samples produces NOUT output lanes, lane k = sum x[k+t]*f[t].
// Two pipeline stages: stage 1 holds all products, stage 2 holds the
// registered sums (truncated or saturated to OW bits) and overflow flags.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - conv1d_pe_if.slave: flt_load/flt_in, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data/ovf
//
// state | meaning
// NOFLT | no filter loaded since reset; windows are refused
// RUN   | filter loaded; windows accepted subject to back-pressure
module conv1d_pe #(
  parameter int DW   = 2,
  parameter int TAPS = 3,
  parameter int NOUT = 3,
  parameter int OW   = 2,
  parameter int SAT  = 0
) (
  input logic         clk,
  input logic         rst,
  conv1d_pe_if.slave  bus
);
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(TAPS);
  // One spare bit above max(SW, OW) so 2^OW-1 and the full sum both fit.
  localparam int CW = ((SW > OW) ? SW : OW) + 1;
  localparam logic [CW-1:0] OMAX = (CW'(1) << OW) - CW'(1);

  typedef enum logic {NOFLT, RUN} state_t;

  state_t                state_q, state_d;
  logic [TAPS*DW-1:0]    flt_q;
  logic                  s1_valid, s2_valid;
  logic                  s1_adv, accept, in_ready_c;
  logic [PW-1:0]         prod_d [NOUT][TAPS];
  logic [PW-1:0]         prod_q [NOUT][TAPS];
  logic [NOUT*OW-1:0]    data_d, data_q;
  logic [NOUT-1:0]       ovf_d, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= NOFLT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    s1_adv     = s1_valid && (!s2_valid || bus.out_ready);
    case (state_q)
      NOFLT: if (bus.flt_load) state_d = RUN;
      RUN:   in_ready_c = !bus.flt_load && (!s1_valid || s1_adv);
      default: state_d = NOFLT;
    endcase
  end

  assign accept = bus.in_valid && in_ready_c;

  // Products use the filter register as it stands before this edge, so a
  // load never affects a window accepted in the same or an earlier cycle.
  always_comb begin
    for (int k = 0; k < NOUT; k++) begin
      for (int t = 0; t < TAPS; t++) begin
        prod_d[k][t] = PW'(bus.in_data[(k+t)*DW +: DW]) * PW'(flt_q[t*DW +: DW]);
      end
    end
  end

  always_comb begin
    logic [CW-1:0] sum;
    data_d = '0;
    ovf_d  = '0;
    sum    = '0;
    for (int k = 0; k < NOUT; k++) begin
      sum = '0;
      for (int t = 0; t < TAPS; t++) begin
        sum = sum + CW'(prod_q[k][t]);
      end
      ovf_d[k] = (sum > OMAX);
      if ((SAT != 0) && ovf_d[k]) data_d[k*OW +: OW] = {OW{1'b1}};
      else                        data_d[k*OW +: OW] = sum[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) prod_q <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q    <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      data_q   <= '0;
      ovf_q    <= '0;
    end else begin
      if (bus.flt_load) flt_q <= bus.flt_in;

      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      if (s1_adv) begin
        s2_valid <= 1'b1;
        data_q   <= data_d;
        ovf_q    <= ovf_d;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = data_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_conv1d_pe.sv
// tb_conv1d_pe: scoreboard bench for conv1d_pe at default parameters. A
// second instance with SAT=1 sees identical inputs so both output modes are
// checked against the same expected queue.
module tb_conv1d_pe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv1d_pe_if #(.DW(2), .TAPS(3), .NOUT(3), .OW(2)) bus   ();
  conv1d_pe_if #(.DW(2), .TAPS(3), .NOUT(3), .OW(2)) bus_s ();

  conv1d_pe #(.DW(2), .TAPS(3), .NOUT(3), .OW(2), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  conv1d_pe #(.DW(2), .TAPS(3), .NOUT(3), .OW(2), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .bus(bus_s.slave));

  assign bus_s.flt_load  = bus.flt_load;
  assign bus_s.flt_in    = bus.flt_in;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.out_ready = bus.out_ready;

  typedef struct packed {
    logic [5:0] d0;
    logic [5:0] d1;
    logic [2:0] ov;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         n_out = 0;
  int         n_refused = 0;
  logic [5:0] mflt = '0;
  logic       stalled = 1'b0;
  logic [5:0] held_d;
  logic [2:0] held_ov;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [9:0] x, input logic [5:0] f);
    exp_t e;
    int   s;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      s = 0;
      for (int t = 0; t < 3; t++) s += int'(x[(k+t)*2 +: 2]) * int'(f[t*2 +: 2]);
      e.d0[k*2 +: 2] = s[1:0];
      e.d1[k*2 +: 2] = (s > 3) ? 2'd3 : s[1:0];
      e.ov[k]        = (s > 3);
    end
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      mflt    = '0;
      stalled = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) sbq.push_back(model(bus.in_data, mflt));
      if (bus.in_valid && !bus.in_ready) n_refused++;
      if (bus.flt_load) begin
        chk("ready_during_load", bus.in_ready, 0);
        mflt = bus.flt_in;
      end
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held_d);
        chk("stall_ovf", bus.ovf, held_ov);
      end
      chk("sat_valid_match", bus_s.out_valid, bus.out_valid);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.d0);
          chk("out_ovf", bus.ovf, e.ov);
          chk("sat_data", bus_s.out_data, e.d1);
          chk("sat_ovf", bus_s.ovf, e.ov);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_ov = bus.ovf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] f);
    bus.flt_load = 1'b1;
    bus.flt_in   = f;
    tick();
    bus.flt_load = 1'b0;
  endtask

  task automatic send(input logic [9:0] x);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("send_accept", done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    int lat;
    int out0;
    bus.flt_load  = 1'b0;
    bus.flt_in    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state, then windows offered without a filter are refused.
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ovf", bus.ovf, 0);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h155;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("noflt_in_ready", bus.in_ready, 0);
      chk("noflt_out_valid", bus.out_valid, 0);
      chk("noflt_out_data", bus.out_data, 0);
      tick();
    end
    bus.in_valid = 1'b0;

    // Identity tap on lane 0, two-cycle latency.
    load(6'b00_00_01);
    send(10'h001);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 2);
    chk("ident_data", bus.out_data, 6'b00_00_01);
    chk("ident_ovf", bus.ovf, 3'b000);
    tick();
    drain();

    // All-ones window with unit taps overflows every lane.
    load(6'b01_01_01);
    send(10'h3FF);
    @(negedge clk);
    @(negedge clk);
    chk("ovf_valid", bus.out_valid, 1);
    chk("ovf_trunc_data", bus.out_data, 6'b01_01_01);
    chk("ovf_sat_data", bus_s.out_data, 6'b11_11_11);
    chk("ovf_flags", bus.ovf, 3'b111);
    chk("ovf_sat_flags", bus_s.ovf, 3'b111);
    tick();
    drain();

    // Five back-to-back windows with the sink stalled for cycles 3..6.
    load(6'($urandom));
    out0      = n_out;
    n_refused = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(10'($urandom));
      end
      begin
        for (int c = 0; c < 10; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          tick();
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("stall_ready_dropped", (n_refused > 0), 1);
    chk("stall_out_count", n_out - out0, 5);

    // Filter reload while a window is in flight, with in_valid offered.
    load(6'b10_01_11);
    send(10'h2D7);
    bus.flt_load = 1'b1;
    bus.flt_in   = 6'b01_11_10;
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h1B4;
    @(negedge clk);
    chk("load_with_valid_ready", bus.in_ready, 0);
    tick();
    bus.flt_load = 1'b0;
    send(10'h1B4);
    drain();

    // Reset with two windows in flight discards them.
    bus.out_ready = 1'b0;
    send(10'h3A5);
    send(10'h0F3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 0);
      chk("post_rst_out_valid", bus.out_valid, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    load(6'b11_10_01);
    send(10'h26C);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
